// File: rtl/seq_fsm_tbl_prog.sv
// seq_fsm_tbl_prog -- programmable table-driven Mealy FSM.
//
// The transition/output table lives in registers and is loaded through a
// config write port, so one instance can run any Mealy machine with up to
// NSTATES states, IN_W input bits and OUT_W output bits.
//
// Ports
//   clk        clock
//   reset      synchronous, active-high reset
//   en         advance enable (also gates the Mealy output)
//   in_        FSM input
//   state      current state register
//   out        Mealy output, combinational from state/en/in_
//   cfg_we     table write strobe
//   cfg_state  entry row (source state)
//   cfg_in     entry column (input value)
//   cfg_next   next-state field to write
//   cfg_out    output field to write
//   cfg_err    sticky flag, set by a rejected config write, cleared by reset
//
// Build option
//   SEQ_FSM_TBL_PROG_DEFAULT_EN: reset loads a built-in 4-state table
//   instead of clearing the table (needs NSTATES >= 4).

module seq_fsm_tbl_prog #(
    parameter  int NSTATES = 4,
    parameter  int IN_W    = 1,
    parameter  int OUT_W   = 1,
    localparam int SW      = $clog2(NSTATES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [IN_W-1:0]  in_,
    output logic [SW-1:0]    state,
    output logic [OUT_W-1:0] out,
    input  logic             cfg_we,
    input  logic [SW-1:0]    cfg_state,
    input  logic [IN_W-1:0]  cfg_in,
    input  logic [SW-1:0]    cfg_next,
    input  logic [OUT_W-1:0] cfg_out,
    output logic             cfg_err
);

    localparam int NROWS = 1 << SW;
    localparam int NCOLS = 1 << IN_W;

    typedef struct packed {
        logic [SW-1:0]    nxt;
        logic [OUT_W-1:0] o;
    } entry_t;

`ifdef SEQ_FSM_TBL_PROG_DEFAULT_EN
    if (NSTATES < 4) begin : g_nstates_chk
        $error("seq_fsm_tbl_prog: default table needs NSTATES >= 4");
    end
`endif

    // The table is padded out to 2^SW rows. Rows >= NSTATES are cleared on
    // reset and can never be written (such writes are rejected), so an
    // out-of-range state reads {0,0} and falls back to state 0 without an
    // explicit range compare on the lookup path.
    entry_t          r_tbl [NROWS][NCOLS];
    logic [SW-1:0]   r_state;
    logic            r_cfg_err;

    entry_t          w_lkp;
    logic [SW-1:0]   w_nxt_state;
    logic [OUT_W-1:0] w_out;
    logic            w_wr_ok;

    // Zero-extend before comparing so the check stays meaningful when
    // NSTATES is a power of two.
    assign w_wr_ok = ({1'b0, cfg_state} < (SW+1)'(NSTATES)) &&
                     ({1'b0, cfg_next}  < (SW+1)'(NSTATES));

    assign w_lkp = r_tbl[r_state][in_];

    always_comb begin
        w_nxt_state = r_state;
        w_out       = '0;
        if (en) begin
            w_nxt_state = w_lkp.nxt;
            w_out       = w_lkp.o;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= '0;
            r_cfg_err <= 1'b0;
            for (int s = 0; s < NROWS; s++)
                for (int i = 0; i < NCOLS; i++)
                    r_tbl[s][i] <= '0;
`ifdef SEQ_FSM_TBL_PROG_DEFAULT_EN
            r_tbl[0][0] <= '{nxt: SW'(0), o: OUT_W'(0)};
            r_tbl[0][1] <= '{nxt: SW'(1), o: OUT_W'(1)};
            r_tbl[1][0] <= '{nxt: SW'(2), o: OUT_W'(1)};
            r_tbl[1][1] <= '{nxt: SW'(1), o: OUT_W'(0)};
            r_tbl[2][0] <= '{nxt: SW'(0), o: OUT_W'(0)};
            r_tbl[2][1] <= '{nxt: SW'(3), o: OUT_W'(1)};
            r_tbl[3][0] <= '{nxt: SW'(2), o: OUT_W'(0)};
            r_tbl[3][1] <= '{nxt: SW'(1), o: OUT_W'(0)};
`endif
        end else begin
            r_state <= w_nxt_state;
            // Non-blocking update: a lookup of the same entry on this edge
            // still sees the old contents (read-before-write).
            if (cfg_we) begin
                if (w_wr_ok)
                    r_tbl[cfg_state][cfg_in] <= '{nxt: cfg_next, o: cfg_out};
                else
                    r_cfg_err <= 1'b1;
            end
        end
    end

    assign state   = r_state;
    assign out     = w_out;
    assign cfg_err = r_cfg_err;

endmodule
